// File: rtl/rggen_axi4lite_master_if.sv
// AXI4-Lite bus bundle between rggen_axi4lite_master and a register-block slave.
// Member names keep the initiator-side i_/o_ port names of the master.
interface rggen_axi4lite_master_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     o_awvalid;
  logic                     i_awready;
  logic [ADDRESS_WIDTH-1:0] o_awaddr;
  logic [2:0]               o_awprot;
  logic                     o_wvalid;
  logic                     i_wready;
  logic [BUS_WIDTH-1:0]     o_wdata;
  logic [BUS_WIDTH/8-1:0]   o_wstrb;
  logic                     i_bvalid;
  logic                     o_bready;
  logic [1:0]               i_bresp;
  logic                     o_arvalid;
  logic                     i_arready;
  logic [ADDRESS_WIDTH-1:0] o_araddr;
  logic [2:0]               o_arprot;
  logic                     i_rvalid;
  logic                     o_rready;
  logic [BUS_WIDTH-1:0]     i_rdata;
  logic [1:0]               i_rresp;

  modport master (
    output o_awvalid, o_awaddr, o_awprot, o_wvalid, o_wdata, o_wstrb, o_bready,
           o_arvalid, o_araddr, o_arprot, o_rready,
    input  i_awready, i_wready, i_bvalid, i_bresp, i_arready, i_rvalid, i_rdata, i_rresp
  );

  modport slave (
    input  o_awvalid, o_awaddr, o_awprot, o_wvalid, o_wdata, o_wstrb, o_bready,
           o_arvalid, o_araddr, o_arprot, o_rready,
    output i_awready, i_wready, i_bvalid, i_bresp, i_arready, i_rvalid, i_rdata, i_rresp
  );
endinterface

// File: rtl/rggen_axi4lite_master.sv
// Command/response stream to single AXI4-Lite transactions, one outstanding.
// Optional response-wait timeout with drain: define RGGEN_AXI4LITE_MASTER_TIMEOUT_EN.
module rggen_axi4lite_master #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int BUS_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [BUS_WIDTH-1:0]     i_cmd_write_data,
  input  logic [BUS_WIDTH/8-1:0]   i_cmd_strobe,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
  output logic [1:0]               o_rsp_status,
  output logic                     o_rsp_timeout,
  rggen_axi4lite_master_if.master  axi
);
  localparam int STRB_W = BUS_WIDTH / 8;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2");
  end
  if (BUS_WIDTH != 32 && BUS_WIDTH != 64) begin : g_bad_width
    $error("BUS_WIDTH must be 32 or 64");
  end

  typedef enum logic [2:0] {
    IDLE,
    WRITE_REQ,
    WRITE_RESP,
    READ_REQ,
    READ_RESP,
`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
    DRAIN,
`endif
    RESPONSE
  } state_t;

  state_t                   r_state, w_state_nx;
  logic                     r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic                     w_awvalid_nx, w_wvalid_nx, w_arvalid_nx, w_bready_nx, w_rready_nx;
  logic                     r_pend, w_pend_nx;
  logic                     r_write, w_write_nx;
  logic [ADDRESS_WIDTH-1:0] r_addr, w_addr_nx;
  logic [BUS_WIDTH-1:0]     r_wdata, w_wdata_nx;
  logic [STRB_W-1:0]        r_wstrb, w_wstrb_nx;
  logic                     r_rsp_valid, w_rsp_valid_nx;
  logic [BUS_WIDTH-1:0]     r_rdata, w_rdata_nx;
  logic [1:0]               r_status, w_status_nx;
  logic                     w_b_hs, w_r_hs;
`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]         r_count, w_count_nx;
  logic                     r_timeout, w_timeout_nx;
  logic                     w_busy;
`endif

  always_comb begin
    // Channel bookkeeping is state-independent so that a timed-out transaction
    // keeps finishing its handshakes through RESPONSE and DRAIN.
    w_awvalid_nx   = r_awvalid & ~axi.i_awready;
    w_wvalid_nx    = r_wvalid  & ~axi.i_wready;
    w_arvalid_nx   = r_arvalid & ~axi.i_arready;
    w_b_hs         = r_bready & axi.i_bvalid;
    w_r_hs         = r_rready & axi.i_rvalid;
    w_pend_nx      = r_pend & ~w_b_hs & ~w_r_hs;
    w_bready_nx    = w_pend_nx &  r_write & ~w_awvalid_nx & ~w_wvalid_nx;
    w_rready_nx    = w_pend_nx & ~r_write & ~w_arvalid_nx;
    w_state_nx     = r_state;
    w_write_nx     = r_write;
    w_addr_nx      = r_addr;
    w_wdata_nx     = r_wdata;
    w_wstrb_nx     = r_wstrb;
    w_rsp_valid_nx = r_rsp_valid;
    w_rdata_nx     = r_rdata;
    w_status_nx    = r_status;
`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
    w_timeout_nx   = r_timeout;
`endif
    case (r_state)
      IDLE: if (i_cmd_valid) begin
        w_pend_nx  = 1'b1;
        w_write_nx = i_cmd_write;
        w_addr_nx  = i_cmd_address;
        w_wdata_nx = i_cmd_write_data;
        w_wstrb_nx = i_cmd_strobe;
        if (i_cmd_write) begin
          w_awvalid_nx = 1'b1;
          w_wvalid_nx  = 1'b1;
          w_state_nx   = WRITE_REQ;
        end else begin
          w_arvalid_nx = 1'b1;
          w_state_nx   = READ_REQ;
        end
      end
      WRITE_REQ:  if (!w_awvalid_nx && !w_wvalid_nx) w_state_nx = WRITE_RESP;
      WRITE_RESP: if (w_b_hs) begin
        w_rsp_valid_nx = 1'b1;
        w_rdata_nx     = '0;
        w_status_nx    = axi.i_bresp;
        w_state_nx     = RESPONSE;
      end
      READ_REQ:   if (!w_arvalid_nx) w_state_nx = READ_RESP;
      READ_RESP:  if (w_r_hs) begin
        w_rsp_valid_nx = 1'b1;
        w_rdata_nx     = axi.i_rdata;
        w_status_nx    = axi.i_rresp;
        w_state_nx     = RESPONSE;
      end
      RESPONSE: if (i_rsp_ready) begin
        w_rsp_valid_nx = 1'b0;
`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
        w_timeout_nx   = 1'b0;
        w_state_nx     = r_timeout ? DRAIN : IDLE;
`else
        w_state_nx     = IDLE;
`endif
      end
`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
      DRAIN: if (!w_pend_nx) w_state_nx = IDLE;
`endif
      default: w_state_nx = IDLE;
    endcase
`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
    w_busy     = (r_state == WRITE_REQ) || (r_state == WRITE_RESP) ||
                 (r_state == READ_REQ)  || (r_state == READ_RESP);
    w_count_nx = w_busy ? r_count + CNT_W'(1) : r_count;
    // Last allowed wait cycle and the transaction is still not done: give up.
    if (w_busy && r_count == CNT_W'(TIMEOUT_CYCLES - 1) && w_state_nx != RESPONSE) begin
      w_state_nx     = RESPONSE;
      w_rsp_valid_nx = 1'b1;
      w_rdata_nx     = '0;
      w_status_nx    = 2'b10;
      w_timeout_nx   = 1'b1;
    end
    if (w_state_nx == IDLE) w_count_nx = '0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_pend      <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_status    <= 2'b00;
`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
      r_count     <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_awvalid   <= w_awvalid_nx;
      r_wvalid    <= w_wvalid_nx;
      r_arvalid   <= w_arvalid_nx;
      r_bready    <= w_bready_nx;
      r_rready    <= w_rready_nx;
      r_pend      <= w_pend_nx;
      r_write     <= w_write_nx;
      r_addr      <= w_addr_nx;
      r_wdata     <= w_wdata_nx;
      r_wstrb     <= w_wstrb_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rdata     <= w_rdata_nx;
      r_status    <= w_status_nx;
`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
      r_count     <= w_count_nx;
      r_timeout   <= w_timeout_nx;
`endif
    end
  end

  assign o_cmd_ready     = (r_state == IDLE);
  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_read_data = r_rdata;
  assign o_rsp_status    = r_status;
`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
  assign o_rsp_timeout   = r_timeout;
`else
  assign o_rsp_timeout   = 1'b0;
`endif

  assign axi.o_awvalid = r_awvalid;
  assign axi.o_awaddr  = r_addr;
  assign axi.o_awprot  = 3'b000;
  assign axi.o_wvalid  = r_wvalid;
  assign axi.o_wdata   = r_wdata;
  assign axi.o_wstrb   = r_wstrb;
  assign axi.o_bready  = r_bready;
  assign axi.o_arvalid = r_arvalid;
  assign axi.o_araddr  = r_addr;
  assign axi.o_arprot  = 3'b000;
  assign axi.o_rready  = r_rready;
endmodule

// File: tb/tb_rggen_axi4lite_master.sv
// Bench for rggen_axi4lite_master: directed cases plus randomized traffic against
// a command-level memory model; a behavioural AXI slave with random stalls.
module tb_rggen_axi4lite_master;
  localparam int AW = 16;
  localparam int BW = 32;
`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [BW-1:0] cmd_wdata;
  logic [3:0]    cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [BW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;

  rggen_axi4lite_master_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) axi();

  rggen_axi4lite_master #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_address(cmd_addr), .i_cmd_write_data(cmd_wdata), .i_cmd_strobe(cmd_strb),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_read_data(rsp_rdata),
    .o_rsp_status(rsp_status), .o_rsp_timeout(rsp_timeout),
    .axi(axi)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave configuration, set by the driver between transactions.
  int         cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0] cfg_resp = 2'b00;
  bit         cfg_no_r = 1'b0;

  logic [BW-1:0] slv_mem [logic [AW-1:0]];
  logic [BW-1:0] mdl_mem [logic [AW-1:0]];

  function automatic logic [BW-1:0] merge(input logic [BW-1:0] old, input logic [BW-1:0] d,
                                          input logic [3:0] s);
    logic [BW-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // AXI slave: decisions at negedge, handshakes land on the following posedge.
  initial begin : slave
    bit aw_c, w_c, b_c, ar_c, r_c, aw_d, w_d, ar_d;
    int aw_n, w_n, b_n, ar_n, r_n;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [BW-1:0] s_wdata, old;
    logic [3:0]    s_wstrb;
    {aw_c, w_c, b_c, ar_c, r_c, aw_d, w_d, ar_d} = '0;
    {aw_n, w_n, b_n, ar_n, r_n} = '0;
    axi.i_awready = 0; axi.i_wready = 0; axi.i_bvalid = 0; axi.i_bresp = 0;
    axi.i_arready = 0; axi.i_rvalid = 0; axi.i_rdata = 0; axi.i_rresp = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        {aw_c, w_c, b_c, ar_c, r_c, aw_d, w_d, ar_d} = '0;
        {aw_n, w_n, b_n, ar_n, r_n} = '0;
        axi.i_awready = 0; axi.i_wready = 0; axi.i_bvalid = 0;
        axi.i_arready = 0; axi.i_rvalid = 0;
        continue;
      end
      if (aw_c) begin aw_c = 0; aw_d = 1; axi.i_awready = 0; end
      if (axi.o_awvalid && !aw_d && !axi.i_awready) begin
        if (aw_n >= cfg_aw_dly) axi.i_awready = 1; else aw_n++;
      end
      if (axi.i_awready && axi.o_awvalid) begin aw_c = 1; s_awaddr = axi.o_awaddr; end
      if (w_c) begin w_c = 0; w_d = 1; axi.i_wready = 0; end
      if (axi.o_wvalid && !w_d && !axi.i_wready) begin
        if (w_n >= cfg_w_dly) axi.i_wready = 1; else w_n++;
      end
      if (axi.i_wready && axi.o_wvalid) begin
        w_c = 1; s_wdata = axi.o_wdata; s_wstrb = axi.o_wstrb;
      end
      if (b_c) begin
        b_c = 0; axi.i_bvalid = 0; aw_d = 0; w_d = 0; aw_n = 0; w_n = 0; b_n = 0;
      end else if (aw_d && w_d && !axi.i_bvalid) begin
        if (b_n >= cfg_b_dly) begin
          old = slv_mem.exists(s_awaddr) ? slv_mem[s_awaddr] : '0;
          slv_mem[s_awaddr] = merge(old, s_wdata, s_wstrb);
          axi.i_bvalid = 1; axi.i_bresp = cfg_resp;
        end else b_n++;
      end
      if (axi.i_bvalid && axi.o_bready) b_c = 1;
      if (ar_c) begin ar_c = 0; ar_d = 1; axi.i_arready = 0; end
      if (axi.o_arvalid && !ar_d && !axi.i_arready) begin
        if (ar_n >= cfg_ar_dly) axi.i_arready = 1; else ar_n++;
      end
      if (axi.i_arready && axi.o_arvalid) begin ar_c = 1; s_araddr = axi.o_araddr; end
      if (r_c) begin
        r_c = 0; axi.i_rvalid = 0; ar_d = 0; ar_n = 0; r_n = 0;
      end else if (ar_d && !axi.i_rvalid && !cfg_no_r) begin
        if (r_n >= cfg_r_dly) begin
          axi.i_rvalid = 1; axi.i_rresp = cfg_resp;
          axi.i_rdata = slv_mem.exists(s_araddr) ? slv_mem[s_araddr] : '0;
        end else r_n++;
      end
      if (axi.i_rvalid && axi.o_rready) r_c = 1;
    end
  end

  // AXI rule monitor: a valid without handshake must stay up with stable payload.
  int aw_hi = 0, w_hi = 0;
  initial begin : monitor
    logic p_aw, p_awr, p_w, p_wr, p_ar, p_arr, p_rst;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [BW-1:0] p_wdata;
    logic [3:0]    p_wstrb;
    p_rst = 1;
    forever begin
      @(negedge clk); #1;
      if (!rst && !p_rst) begin
        if (p_aw && !p_awr) begin
          chk("awvalid_hold", axi.o_awvalid, 1); chk("awaddr_stable", axi.o_awaddr, p_awaddr);
        end
        if (p_w && !p_wr) begin
          chk("wvalid_hold", axi.o_wvalid, 1); chk("wdata_stable", axi.o_wdata, p_wdata);
          chk("wstrb_stable", axi.o_wstrb, p_wstrb);
        end
        if (p_ar && !p_arr) begin
          chk("arvalid_hold", axi.o_arvalid, 1); chk("araddr_stable", axi.o_araddr, p_araddr);
        end
      end
      if (axi.o_awvalid) aw_hi++;
      if (axi.o_wvalid)  w_hi++;
      p_rst = rst;
      p_aw = axi.o_awvalid; p_awr = axi.i_awready; p_awaddr = axi.o_awaddr;
      p_w  = axi.o_wvalid;  p_wr  = axi.i_wready;  p_wdata = axi.o_wdata; p_wstrb = axi.o_wstrb;
      p_ar = axi.o_arvalid; p_arr = axi.i_arready; p_araddr = axi.o_araddr;
    end
  end

  // Called at a negedge; returns at the negedge right after the response handshake.
  task automatic do_txn(input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] d,
                        input logic [3:0] s, input int hold, output int lat,
                        output logic [BW-1:0] rd, output logic [1:0] st, output logic to);
    int n;
    lat = 0; rd = 'x; st = 'x; to = 'x;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin chk("cmd_accept_bound", 0, 1); cmd_valid = 0; return; end
    @(negedge clk); cmd_valid = 0; lat = 1;
    while (!rsp_valid && lat < 400) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin chk("rsp_wait_bound", 0, 1); return; end
    rd = rsp_rdata; st = rsp_status; to = rsp_timeout;
    for (int h = 0; h < hold; h++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, rd);
      chk("hold_status", rsp_status, st);
      chk("hold_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1; @(negedge clk); rsp_ready = 0;
  endtask

  task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r,
                         input logic [1:0] resp);
    cfg_aw_dly = aw; cfg_w_dly = w; cfg_b_dly = b; cfg_ar_dly = ar; cfg_r_dly = r;
    cfg_resp = resp;
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat, n;
    logic [BW-1:0] rd, d, expd;
    logic [1:0] st, resp;
    logic to;
    logic [AW-1:0] a;
    logic [3:0] s;
    bit wr;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
    rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_valids", {axi.o_awvalid, axi.o_wvalid, axi.o_arvalid, axi.o_bready,
                       axi.o_rready, rsp_valid}, 6'b0);
    chk("rst_addr", {axi.o_awaddr, axi.o_araddr}, 0);
    chk("rst_wdata_wstrb", {axi.o_wdata, axi.o_wstrb}, 0);
    chk("rst_rsp", {rsp_rdata, rsp_status, rsp_timeout}, 0);
    chk("prot", {axi.o_awprot, axi.o_arprot}, 0);
    rst = 0;
    @(negedge clk);

    // Zero-wait read
    slv_mem[16'h0010] = 32'h000000A5; mdl_mem[16'h0010] = 32'h000000A5;
    set_dly(0, 0, 0, 0, 0, 2'b00);
    do_txn(0, 16'h0010, 0, 0, 0, lat, rd, st, to);
    chk("rd0_latency", lat, 3); chk("rd0_data", rd, 32'hA5); chk("rd0_status", st, 0);
    chk("rd0_cmd_ready_after", cmd_ready, 1);

    // Write with slow AWREADY
    set_dly(3, 0, 0, 0, 0, 2'b00);
    aw_hi = 0; w_hi = 0;
    do_txn(1, 16'h0004, 32'h12345678, 4'b0001, 0, lat, rd, st, to);
    mdl_mem[16'h0004] = merge(0, 32'h12345678, 4'b0001);
    chk("wr_aw_cycles", aw_hi, 4); chk("wr_w_cycles", w_hi, 1);
    chk("wr_status", st, 0); chk("wr_rdata_zero", rd, 0);

    // Error response held by a stalled consumer
    set_dly(0, 0, 0, 0, 0, 2'b10);
    do_txn(1, 16'h0008, 32'hCAFEF00D, 4'hF, 5, lat, rd, st, to);
    mdl_mem[16'h0008] = 32'hCAFEF00D;
    chk("slverr_status", st, 2'b10); chk("slverr_timeout", to, 0);

    // Back-to-back write then read of the same word
    set_dly(0, 0, 0, 0, 0, 2'b00);
    do_txn(1, 16'h0020, 32'h0BADBEEF, 4'hF, 0, lat, rd, st, to);
    mdl_mem[16'h0020] = 32'h0BADBEEF;
    chk("b2b_wr_latency", lat, 3);
    chk("b2b_cmd_ready", cmd_ready, 1);
    do_txn(0, 16'h0020, 0, 0, 0, lat, rd, st, to);
    chk("b2b_rd_latency", lat, 3); chk("b2b_rd_data", rd, mdl_mem[16'h0020]);

    // Reset while waiting for R
    set_dly(0, 0, 0, 0, 8, 2'b00);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 16'h0010;
    @(negedge clk); cmd_valid = 0;
    n = 0;
    while (!axi.o_rready && n < 20) begin @(negedge clk); n++; end
    chk("rst_test_reached_rresp", axi.o_rready, 1);
    rst = 1; @(negedge clk);
    chk("midrst_rready", axi.o_rready, 0); chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    @(negedge clk); rst = 0; @(negedge clk);
    set_dly(0, 0, 0, 0, 0, 2'b01);
    do_txn(0, 16'h0010, 0, 0, 0, lat, rd, st, to);
    chk("post_rst_data", rd, 32'hA5); chk("post_rst_status", st, 2'b01);

    // Randomized traffic against the command-level model
    for (int i = 0; i < 40; i++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = 16'h0100 + AW'({$urandom_range(0, 5), 2'b00});
      d    = $urandom;
      s    = 4'($urandom_range(0, 15));
      resp = 2'($urandom_range(0, 3));
      set_dly($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2), resp);
      expd = mdl_mem.exists(a) ? mdl_mem[a] : '0;
      if (wr) begin
        mdl_mem[a] = merge(expd, d, s);
        expd = '0;
      end
      do_txn(wr, a, d, s, $urandom_range(0, 2), lat, rd, st, to);
      chk(wr ? "rand_wr_rdata" : "rand_rd_rdata", rd, expd);
      chk("rand_status", st, resp);
      chk("rand_timeout", to, 0);
      chk("rand_cmd_ready_after", cmd_ready, 1);
    end

`ifdef RGGEN_AXI4LITE_MASTER_TIMEOUT_EN
    // Read whose R never arrives in time, then drained once it finally does
    set_dly(0, 0, 0, 0, 0, 2'b00);
    cfg_no_r = 1;
    do_txn(0, 16'h0010, 0, 0, 0, lat, rd, st, to);
    chk("to_latency", lat, TO + 1);
    chk("to_status", st, 2'b10); chk("to_flag", to, 1); chk("to_rdata", rd, 0);
    for (int k = 0; k < 3; k++) begin
      chk("drain_cmd_ready", cmd_ready, 0); chk("drain_rready", axi.o_rready, 1);
      @(negedge clk);
    end
    cfg_no_r = 0;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("drain_done", cmd_ready, 1);
    chk("drain_no_rsp", rsp_valid, 0);
    do_txn(0, 16'h0010, 0, 0, 0, lat, rd, st, to);
    chk("after_drain_data", rd, 32'hA5); chk("after_drain_flag", to, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
